mult3_unit: RTL and testbench

- Multi-cycle integer multiply execution unit for the 5-stage RISC-V pipeline.
- It consumes the decoded R-type MUL issue from the EX stage and computes the low 32 bits of rs1*rs2 over three internal cycles.
- While it works, it drives a stall request back to the hazard/control logic.
- It returns the result, the destination register and a write-back strobe toward EX/MEM.

---
 rtl/mult3_unit.sv | 103 ++++++++++
 tb/tb_mult3_unit.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mult3_unit.sv
// Three-cycle MUL execution unit: low DATA_W bits of op_a*op_b via two half-width partial products.
// Stalls the front of the pipeline while working and pulses done/reg_write with the result.
module mult3_unit #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  start,
    input  logic                  flush,
    input  logic [DATA_W-1:0]     op_a,
    input  logic [DATA_W-1:0]     op_b,
    input  logic [REG_ADDR_W-1:0] rd_in,
    output logic                  stall,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_W-1:0]     result,
    output logic [REG_ADDR_W-1:0] rd_out,
    output logic                  reg_write
);

    localparam int unsigned HALF_W = DATA_W / 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        M1   = 2'd1,
        M2   = 2'd2,
        M3   = 2'd3
    } state_t;

    state_t                  state;
    state_t                  next_state;
    logic                    accept_c;
    logic [DATA_W-1:0]       a_q;
    logic [DATA_W-1:0]       b_q;
    logic [REG_ADDR_W-1:0]   rd_q;
    logic [DATA_W-1:0]       pp_lo;
    logic [DATA_W-1:0]       pp_hi;

    assign accept_c = (state == IDLE) && start && !flush;

    // Stall covers the issue cycle and M1/M2; dropping it in M3 lets the held MUL leave EX.
    assign stall = accept_c || (state == M1) || (state == M2);
    assign busy  = (state != IDLE);

    // State register.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; flush aborts any in-flight operation.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = accept_c ? M1 : IDLE;
            M1:      next_state = flush ? IDLE : M2;
            M2:      next_state = flush ? IDLE : M3;
            M3:      next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Operand latch, partial products and registered write-back outputs.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            a_q       <= '0;
            b_q       <= '0;
            rd_q      <= '0;
            pp_lo     <= '0;
            pp_hi     <= '0;
            result    <= '0;
            rd_out    <= '0;
            done      <= 1'b0;
            reg_write <= 1'b0;
        end else begin
            done      <= (state == M3) && !flush;
            reg_write <= (state == M3) && !flush;
            case (state)
                IDLE: begin
                    if (accept_c) begin
                        a_q  <= op_a;
                        b_q  <= op_b;
                        rd_q <= rd_in;
                    end
                end
                M1: pp_lo <= a_q * DATA_W'(b_q[HALF_W-1:0]);
                M2: pp_hi <= (a_q * DATA_W'(b_q[DATA_W-1:HALF_W])) << HALF_W;
                M3: begin
                    if (!flush) begin
                        result <= pp_lo + pp_hi;
                        rd_out <= rd_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult3_unit.sv
// Directed bench for mult3_unit: vector table through the full issue/latency sequence,
// plus back-to-back, flush and asynchronous reset corner cases.
module tb_mult3_unit;

    logic        clk = 1'b0;
    logic        arst;
    logic        start;
    logic        flush;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  rd_in;
    logic        stall;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rd_out;
    logic        reg_write;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[5];

    mult3_unit dut (
        .clk       (clk),
        .arst      (arst),
        .start     (start),
        .flush     (flush),
        .op_a      (op_a),
        .op_b      (op_b),
        .rd_in     (rd_in),
        .stall     (stall),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .rd_out    (rd_out),
        .reg_write (reg_write)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        op_a  = a;
        op_b  = b;
        rd_in = rd;
        start = 1'b1;
        flush = 1'b0;
    endtask

    // Full single-op sequence starting in IDLE: checks stall profile, T+4 write-back and T+5 hold.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] exp);
        issue(a, b, rd);
        #1;
        chk("stall_T", 32'(stall), 32'd1);
        step();
        chk("stall_T1", 32'(stall), 32'd1);
        chk("busy_T1", 32'(busy), 32'd1);
        step();
        chk("stall_T2", 32'(stall), 32'd1);
        step();
        chk("stall_T3", 32'(stall), 32'd0);
        chk("done_T3", 32'(done), 32'd0);
        step();
        start = 1'b0;
        #1;
        chk("done_T4", 32'(done), 32'd1);
        chk("reg_write_T4", 32'(reg_write), 32'd1);
        chk("result_T4", result, exp);
        chk("rd_out_T4", 32'(rd_out), 32'(rd));
        chk("busy_T4", 32'(busy), 32'd0);
        step();
        chk("done_T5", 32'(done), 32'd0);
        chk("result_T5", result, exp);
    endtask

    initial begin
        vecs[0] = '{a: 32'd7,          b: 32'd6,          rd: 5'd5,  exp: 32'd42};
        vecs[1] = '{a: 32'hFFFF_FFFF,  b: 32'd2,          rd: 5'd10, exp: 32'hFFFF_FFFE};
        vecs[2] = '{a: 32'h0001_0000,  b: 32'h0001_0000,  rd: 5'd0,  exp: 32'h0000_0000};
        vecs[3] = '{a: 32'h1234_5678,  b: 32'h9ABC_DEF0,  rd: 5'd17, exp: 32'h242D_2080};
        vecs[4] = '{a: 32'h8000_0000,  b: 32'd3,          rd: 5'd31, exp: 32'h8000_0000};

        arst  = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        op_a  = '0;
        op_b  = '0;
        rd_in = '0;
        #12;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_rd_out", 32'(rd_out), 32'd0);
        chk("rst_reg_write", 32'(reg_write), 32'd0);
        arst = 1'b0;
        step();

        for (int i = 0; i < 5; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].exp);
        end

        // Back-to-back: second issue lands in the done cycle of the first.
        issue(32'd3, 32'd4, 5'd1);
        step();
        step();
        step();
        step();
        issue(32'd5, 32'd5, 5'd2);
        #1;
        chk("b2b_done1", 32'(done), 32'd1);
        chk("b2b_result1", result, 32'd12);
        chk("b2b_rd1", 32'(rd_out), 32'd1);
        chk("b2b_stall_accept", 32'(stall), 32'd1);
        step();
        chk("b2b_no_extra_done", 32'(done), 32'd0);
        chk("b2b_result_held", result, 32'd12);
        step();
        chk("b2b_done_T6", 32'(done), 32'd0);
        step();
        chk("b2b_done_T7", 32'(done), 32'd0);
        step();
        start = 1'b0;
        #1;
        chk("b2b_done2", 32'(done), 32'd1);
        chk("b2b_result2", result, 32'd25);
        chk("b2b_rd2", 32'(rd_out), 32'd2);
        step();
        chk("b2b_done_after", 32'(done), 32'd0);

        // Flush while in M2: op is dropped, prior result preserved.
        issue(32'd11, 32'd11, 5'd9);
        step();
        step();
        flush = 1'b1;
        #1;
        step();
        chk("flush_idle", 32'(busy), 32'd0);
        chk("flush_start_blocked", 32'(stall), 32'd0);
        step();
        chk("flush_not_accepted", 32'(busy), 32'd0);
        start = 1'b0;
        flush = 1'b0;
        #1;
        chk("flush_stall_low", 32'(stall), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("flush_no_done", 32'(done), 32'd0);
        end
        chk("flush_result_kept", result, 32'd25);
        chk("flush_rd_kept", 32'(rd_out), 32'd2);

        // Asynchronous reset in the middle of M1.
        issue(32'd13, 32'd13, 5'd3);
        step();
        chk("pre_rst_busy", 32'(busy), 32'd1);
        start = 1'b0;
        #2;
        arst = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_stall", 32'(stall), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_result", result, 32'd0);
        chk("arst_rd_out", 32'(rd_out), 32'd0);
        chk("arst_reg_write", 32'(reg_write), 32'd0);
        #2;
        arst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("post_rst_no_done", 32'(done), 32'd0);
            chk("post_rst_idle", 32'(busy), 32'd0);
        end
        run_op(32'd9, 32'd9, 5'd7, 32'd81);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
